act_share_arbiter: RTL and testbench



---
 rtl/act_pkg.sv | 16 +
 rtl/act_out_fifo.sv | 51 +++++
 rtl/activation_lrelu.sv | 50 +++++
 rtl/act_share_arbiter.sv | 162 ++++++++++++++++
 tb/tb_act_share_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/act_pkg.sv
// Shared constants and types for the activation-sharing arbiter slice.
package act_pkg;

  // Q8.8 sample format
  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;

  // LeakyReLU negative slope, Q0.8 (0x1A / 256 ~= 0.1016)
  localparam logic [7:0] LRELU_ALPHA = 8'h1A;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/act_out_fifo.sv
// Small synchronous FIFO with occupancy count; head is read straight
// from the storage registers so out_valid follows the write by one cycle.
module act_out_fifo #(
  parameter  int WIDTH = 19,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_pop;

  assign do_pop = pop_i && (count_q != '0);

  // Storage, pointers and count; simultaneous push/pop leaves count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/activation_lrelu.sv
// Registered LeakyReLU unit. Negative samples are scaled by ALPHA (Q0.8)
// with an arithmetic (floor) shift; zero/positive samples pass unchanged.
module activation_lrelu #(
  parameter int         DATA_WIDTH = act_pkg::DATA_WIDTH,
  parameter logic [7:0] ALPHA      = act_pkg::LRELU_ALPHA,
  parameter bit         PIPELINED  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] y_o
);
  import act_pkg::*;

  logic signed [DATA_WIDTH+8:0] prod;
  logic        [DATA_WIDTH-1:0] y_d;

  // Signed sample times zero-extended slope; keep bits [DATA_WIDTH+7:FRAC_BITS]
  always_comb begin
    prod = $signed(x_i) * $signed({1'b0, ALPHA});
    y_d  = x_i[DATA_WIDTH-1] ? DATA_WIDTH'(prod >>> FRAC_BITS) : x_i;
  end

  generate
    if (PIPELINED) begin : g_pipe
      logic                  valid_q;
      logic [DATA_WIDTH-1:0] y_q;

      // One-cycle output register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          y_q     <= '0;
        end else begin
          valid_q <= in_valid_i;
          y_q     <= y_d;
        end
      end

      assign out_valid_o = valid_q;
      assign y_o         = y_q;
    end else begin : g_comb
      assign out_valid_o = in_valid_i;
      assign y_o         = y_d;
    end
  endgenerate

endmodule

// File: rtl/act_share_arbiter.sv
// Round-robin, packet-locked sharing of one registered LeakyReLU stage
// among NUM_REQ streaming requesters, with a credit-gated output FIFO.
module act_share_arbiter #(
  parameter int         DATA_WIDTH = act_pkg::DATA_WIDTH,
  parameter int         NUM_REQ    = 4,
  parameter int         ID_W       = 2,
  parameter logic [7:0] ALPHA      = act_pkg::LRELU_ALPHA,
  parameter int         OUT_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            cfg_bypass,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]               out_id,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic                          busy
);
  import act_pkg::*;

  localparam int           CNT_W     = $clog2(OUT_DEPTH) + 1;
  localparam int           FW        = DATA_WIDTH + ID_W + 1;
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(OUT_DEPTH);

  arb_state_e      state_q;
  logic [ID_W-1:0] grant_q;
  logic [ID_W-1:0] rr_ptr_q;

  logic            sel_found;
  logic [ID_W-1:0] sel_idx;
  logic [ID_W-1:0] grantee;
  logic [ID_W-1:0] next_ptr;
  logic            grant_active;
  logic            credit;
  logic            accept;
  logic [DATA_WIDTH-1:0] acc_data;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic [CNT_W:0]   outstanding;

  logic                  stage_valid;
  logic [DATA_WIDTH-1:0] lrelu_y;
  logic [DATA_WIDTH-1:0] stage_data;
  logic [ID_W-1:0]       sb_id_q;
  logic                  sb_last_q;
  logic                  sb_byp_q;
  logic [DATA_WIDTH-1:0] sb_raw_q;
  logic [FW-1:0]         fifo_rdata;

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ
  always_comb begin
    int cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(cand);
      end
    end
  end

  // Credit counts beats in the stage as well as beats held in the FIFO;
  // a pop this cycle is deliberately not credited.
  assign outstanding  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, stage_valid};
  assign credit       = (outstanding < DEPTH_LIM);
  assign grantee      = (state_q == LOCKED) ? grant_q : sel_idx;
  assign grant_active = (state_q == LOCKED) || sel_found;
  assign accept       = grant_active && credit && req_valid[grantee];
  assign acc_data     = req_data[int'(grantee)*DATA_WIDTH +: DATA_WIDTH];
  assign next_ptr     = (grantee == ID_W'(NUM_REQ - 1)) ? '0 : grantee + 1'b1;

  // Only the current grantee sees ready, and only while credit remains
  always_comb begin
    req_ready = '0;
    if (grant_active && credit) req_ready[grantee] = 1'b1;
  end

  // Arbitration FSM: lock on first beat, release and advance rr_ptr on last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (req_last[grantee]) begin
            rr_ptr_q <= next_ptr;
          end else begin
            state_q <= LOCKED;
            grant_q <= grantee;
          end
        end
        LOCKED: begin
          if (req_last[grantee]) begin
            state_q  <= IDLE;
            rr_ptr_q <= next_ptr;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  activation_lrelu #(
    .DATA_WIDTH (DATA_WIDTH),
    .ALPHA      (ALPHA),
    .PIPELINED  (1'b1)
  ) u_lrelu (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (accept),
    .x_i         (acc_data),
    .out_valid_o (stage_valid),
    .y_o         (lrelu_y)
  );

  // Sideband travelling with the stage: ID, last flag, bypass select, raw sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_id_q   <= '0;
      sb_last_q <= 1'b0;
      sb_byp_q  <= 1'b0;
      sb_raw_q  <= '0;
    end else if (accept) begin
      sb_id_q   <= grantee;
      sb_last_q <= req_last[grantee];
      sb_byp_q  <= cfg_bypass[grantee];
      sb_raw_q  <= acc_data;
    end
  end

  assign stage_data = sb_byp_q ? sb_raw_q : lrelu_y;

  act_out_fifo #(
    .WIDTH (FW),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (stage_valid),
    .wdata_i ({stage_data, sb_id_q, sb_last_q}),
    .pop_i   (out_ready),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign {out_data, out_id, out_last} = fifo_rdata;
  assign busy = (state_q == LOCKED) || stage_valid || !fifo_empty;

endmodule

// File: tb/tb_act_share_arbiter.sv
// Bench for act_share_arbiter: transaction-level reference model
// (lock owner, rr pointer, queue of outstanding results) compared every cycle.
module tb_act_share_arbiter;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    cfg_bypass;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_id;
  logic            out_last;
  logic            out_ready;
  logic            busy;

  always #5 clk = ~clk;

  act_share_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (N),
    .ID_W       (2),
    .ALPHA      (8'h1A),
    .OUT_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .cfg_bypass (cfg_bypass),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  typedef struct {
    logic [15:0] data;
    logic [1:0]  id;
    logic        last;
    int          vis;
  } beat_t;

  int     checks = 0;
  int     errors = 0;
  int     pcount = 0;
  beat_t  mq[$];
  beat_t  got[$];
  bit     m_locked;
  int     m_owner;
  int     m_rr;
  logic [N-1:0] acc_mask;
  int     pk_left[N];
  int     pk_beat[N];

  always @(posedge clk) pcount++;

  function automatic logic [15:0] lrelu_ref(logic [15:0] x, logic byp);
    int sx;
    int p;
    if (byp || !x[15]) return x;
    sx = $signed(x);
    p  = sx * 26;
    return 16'(p >>> 8);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, pcount);
    end
  endtask

  function automatic int model_sel();
    if (m_locked) return m_owner;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_rr + k) % N;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  // One cycle: compare DUT against model, advance model, move to next negedge
  task automatic tick();
    int           g;
    bit           credit;
    bit           ev;
    logic [N-1:0] exp_ready;
    beat_t        b;
    #1;
    acc_mask = '0;
    if (rst_n) begin
      g         = model_sel();
      credit    = mq.size() < DEPTH;
      exp_ready = '0;
      if (g >= 0 && credit) exp_ready[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      ev = (mq.size() > 0) && (mq[0].vis <= pcount);
      check("out_valid", 32'(out_valid), 32'(ev));
      check("busy", 32'(busy), 32'(m_locked || mq.size() > 0));
      if (ev) begin
        check("out_data", 32'(out_data), 32'(mq[0].data));
        check("out_id",   32'(out_id),   32'(mq[0].id));
        check("out_last", 32'(out_last), 32'(mq[0].last));
      end
      if (g >= 0 && credit && req_valid[g]) begin
        acc_mask[g] = 1'b1;
        b.data = lrelu_ref(req_data[g*DW +: DW], cfg_bypass[g]);
        b.id   = g[1:0];
        b.last = req_last[g];
        b.vis  = pcount + 2;
        mq.push_back(b);
        if (!m_locked) begin
          if (req_last[g]) m_rr = (g + 1) % N;
          else begin
            m_locked = 1'b1;
            m_owner  = g;
          end
        end else if (req_last[g]) begin
          m_locked = 1'b0;
          m_rr     = (g + 1) % N;
        end
      end
      if (ev && out_ready) begin
        got.push_back(mq[0]);
        void'(mq.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data",  32'(out_data),  32'd0);
    check("rst out_id",    32'(out_id),    32'd0);
    check("rst out_last",  32'(out_last),  32'd0);
    check("rst busy",      32'(busy),      32'd0);
    check("rst req_ready", 32'(req_ready), 32'd0);
    mq.delete();
    m_locked = 1'b0;
    m_owner  = 0;
    m_rr     = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(int n);
    req_valid = '0;
    req_last  = '0;
    repeat (n) tick();
  endtask

  task automatic send1(int r, logic [15:0] d, logic byp);
    int n = 0;
    req_valid    = '0;
    req_valid[r] = 1'b1;
    req_last     = '0;
    req_last[r]  = 1'b1;
    req_data[r*DW +: DW] = d;
    cfg_bypass[r] = byp;
    do begin
      tick();
      n++;
    end while (!acc_mask[r] && n < 20);
    checks++;
    if (!acc_mask[r]) begin
      errors++;
      $display("FAIL send1 timeout: req %0d not accepted within %0d cycles", r, n);
    end
    req_valid = '0;
  endtask

  // Drive the packets described by pk_left[] until done or budget spent
  task automatic run_packets(int max_cycles, output bit done);
    int  n = 0;
    bit  any;
    do begin
      any = 1'b0;
      for (int i = 0; i < N; i++) if (pk_left[i] > 0) any = 1'b1;
      if (any) begin
        for (int i = 0; i < N; i++) begin
          req_valid[i]  = pk_left[i] > 0;
          req_last[i]   = pk_left[i] == 1;
          req_data[i*DW +: DW] = 16'(i * 256 + pk_beat[i]);
          cfg_bypass[i] = 1'b0;
        end
        tick();
        for (int i = 0; i < N; i++)
          if (acc_mask[i]) begin
            pk_left[i]--;
            pk_beat[i]++;
          end
        n++;
      end
    end while (any && n < max_cycles);
    req_valid = '0;
    done = !any;
  endtask

  task automatic expect_done(bit done, string name);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: packets not completed within cycle budget", name);
    end
  endtask

  initial begin
    bit done;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    cfg_bypass = '0;
    out_ready  = 1'b1;
    m_locked   = 1'b0;
    m_owner    = 0;
    m_rr       = 0;
    @(negedge clk);
    do_reset();

    // Single beat, positive sample
    got.delete();
    send1(0, 16'h0180, 1'b0);
    drain(5);
    check("t1 count", 32'(got.size()), 32'd1);
    if (got.size() >= 1) begin
      check("t1 data", 32'(got[0].data), 32'h0180);
      check("t1 id",   32'(got[0].id),   32'd0);
      check("t1 last", 32'(got[0].last), 32'd1);
    end

    // Negative scaling: -1.0 -> -26/256; -128.0 -> -13.0 (0xF300); bypass keeps raw
    got.delete();
    send1(0, 16'hFF00, 1'b0);
    send1(0, 16'h8000, 1'b0);
    send1(0, 16'hFF00, 1'b1);
    drain(5);
    check("t2 count", 32'(got.size()), 32'd3);
    if (got.size() >= 3) begin
      check("t2 neg1",   32'(got[0].data), 32'hFFE6);
      check("t2 min",    32'(got[1].data), 32'hF300);
      check("t2 bypass", 32'(got[2].data), 32'hFF00);
    end

    // Contention from rr_ptr = 0: no interleave, order 0,1,2
    do_reset();
    got.delete();
    pk_left = '{3, 3, 3, 0};
    pk_beat = '{0, 0, 0, 0};
    run_packets(100, done);
    expect_done(done, "contention");
    drain(5);
    check("t3 count", 32'(got.size()), 32'd9);
    foreach (got[k]) begin
      check("t3 order id", 32'(got[k].id), 32'(k / 3));
      check("t3 beat", 32'(got[k].data[7:0]), 32'(k % 3));
    end
    // rr_ptr now 3: req 3 beats req 0
    got.delete();
    pk_left = '{1, 0, 0, 1};
    run_packets(20, done);
    expect_done(done, "wrap");
    drain(5);
    check("t3b count", 32'(got.size()), 32'd2);
    if (got.size() >= 2) begin
      check("t3b first",  32'(got[0].id), 32'd3);
      check("t3b second", 32'(got[1].id), 32'd0);
    end

    // Backpressure: exactly DEPTH beats accepted while out_ready low
    got.delete();
    out_ready = 1'b0;
    pk_left = '{0, 8, 0, 0};
    pk_beat = '{0, 0, 0, 0};
    run_packets(12, done);
    check("t4 accepted under stall", 32'(8 - pk_left[1]), 32'(DEPTH));
    out_ready = 1'b1;
    run_packets(100, done);
    expect_done(done, "backpressure");
    drain(6);
    check("t4 count", 32'(got.size()), 32'd8);
    foreach (got[k]) begin
      check("t4 id",   32'(got[k].id),   32'd1);
      check("t4 data", 32'(got[k].data), 32'(16'h0100 + k));
    end

    // Lock hold: req 2 mid-packet stalls, req 3 waits
    got.delete();
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    req_data[2*DW +: DW] = 16'h0222;
    cfg_bypass = '0;
    tick();
    check("t5 first accept", 32'(acc_mask), 32'b0100);
    req_valid = 4'b1000;
    req_last  = 4'b1000;
    req_data[3*DW +: DW] = 16'h0333;
    repeat (5) begin
      tick();
      check("t5 ready3 held", 32'(req_ready[3]), 32'd0);
    end
    req_valid = 4'b1100;
    req_last  = 4'b1100;
    tick();
    check("t5 last accept", 32'(acc_mask), 32'b0100);
    pk_left = '{0, 0, 0, 1};
    pk_beat = '{0, 0, 0, 0};
    run_packets(20, done);
    expect_done(done, "lock hold");
    drain(5);
    check("t5 count", 32'(got.size()), 32'd3);
    if (got.size() >= 3) begin
      check("t5 id0", 32'(got[0].id), 32'd2);
      check("t5 id1", 32'(got[1].id), 32'd2);
      check("t5 id2", 32'(got[2].id), 32'd3);
    end

    // Reset with two beats of an open packet sitting in the FIFO
    out_ready = 1'b0;
    req_valid = 4'b0001;
    req_last  = 4'b0000;
    req_data[0 +: DW] = 16'h0055;
    repeat (2) tick();
    drain(3);
    check("t6 queued before reset", 32'(mq.size()), 32'd2);
    do_reset();
    out_ready = 1'b1;
    got.delete();
    drain(5);
    check("t6 no stale", 32'(got.size()), 32'd0);
    pk_left = '{1, 1, 0, 0};
    pk_beat = '{0, 0, 0, 0};
    run_packets(20, done);
    expect_done(done, "post reset");
    drain(5);
    check("t6 count", 32'(got.size()), 32'd2);
    if (got.size() >= 2) begin
      check("t6 rr restart", 32'(got[0].id), 32'd0);
      check("t6 second",     32'(got[1].id), 32'd1);
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      req_valid  = N'($urandom);
      req_data   = {$urandom, $urandom};
      for (int i = 0; i < N; i++) req_last[i] = ($urandom_range(0, 2) == 0);
      cfg_bypass = N'($urandom);
      out_ready  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 599) == 0) do_reset();
      else tick();
      if (got.size() > 64) got.delete();
    end
    out_ready = 1'b1;
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
